// File: rtl/iterative_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// iterative_multiplier_pkg
// Purpose : shared constants for the execute-stage shift-add multiplier.
//           - operand word width
//           - product-half mode encodings (LEGv8 MUL / SMULH / UMULH)
//           - FSM state type
//           - helper that classifies a mode as high-half or low-half
// Ports   : none (package)
// -----------------------------------------------------------------------------
package iterative_multiplier_pkg;

  localparam int WORD = 64;

  // Mode encodings as delivered by decode; 2'b11 behaves as MUL.
  localparam logic [1:0] MODE_MUL   = 2'b00;
  localparam logic [1:0] MODE_SMULH = 2'b01;
  localparam logic [1:0] MODE_UMULH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } mult_state_e;

  // True when the mode returns the upper half of the 2*WIDTH product.
  function automatic logic is_high_half(input logic [1:0] mode);
    logic high;
    case (mode)
      MODE_SMULH: high = 1'b1;
      MODE_UMULH: high = 1'b1;
      default:    high = 1'b0;
    endcase
    return high;
  endfunction

endpackage

// File: rtl/iterative_multiplier_if.sv
// -----------------------------------------------------------------------------
// iterative_multiplier_if
// Purpose : request/response bundle between decode (master) and the
//           iterative multiplier (slave).
// Signals : start  - request, sampled only while the multiplier is idle
//           mode   - product-half select (MUL / SMULH / UMULH)
//           a, b   - multiplicand (Rn) and multiplier (Rm)
//           busy   - operation in flight
//           done   - one-cycle pulse, result valid
//           result - selected product half, held until the next accepted start
// -----------------------------------------------------------------------------
interface iterative_multiplier_if
  import iterative_multiplier_pkg::*;
#(
  parameter int WIDTH = WORD
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, output mode, output a, output b,
                  input  busy,  input  done, input  result);

  modport slave  (input  start, input  mode, input  a, input  b,
                  output busy,  output done, output result);
endinterface

// File: rtl/iterative_multiplier_twos_negate.sv
// -----------------------------------------------------------------------------
// twos_negate
// Purpose : combinational conditional two's-complement negate.
//           o_out = i_neg ? -i_in : i_in
// Ports   : i_neg - negate enable
//           i_in  - SIZE-bit operand
//           o_out - SIZE-bit result
// -----------------------------------------------------------------------------
module twos_negate #(
  parameter int SIZE = 64
) (
  input  logic            i_neg,
  input  logic [SIZE-1:0] i_in,
  output logic [SIZE-1:0] o_out
);

  logic [SIZE-1:0] w_negated;

  assign w_negated = ~i_in + {{(SIZE-1){1'b0}}, 1'b1};
  assign o_out     = i_neg ? w_negated : i_in;

endmodule

// File: rtl/iterative_multiplier.sv
// -----------------------------------------------------------------------------
// iterative_multiplier
// Purpose : multi-cycle WIDTHxWIDTH shift-add multiplier for the execute
//           stage. Multiplies magnitudes one multiplier bit per cycle, then
//           restores the sign (SMULH only) and returns the requested half.
//           FSM: IDLE -> BUSY -> FIXUP -> DONE -> IDLE.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous, active-low; clears all state
//           bus   - iterative_multiplier_if slave (start/mode/a/b in,
//                   busy/done/result out)
// Options : MULT_EARLY_EXIT_EN - when defined, BUSY ends as soon as the
//           remaining multiplier bits are all zero. Results are identical
//           either way; only the latency changes.
// -----------------------------------------------------------------------------
module iterative_multiplier
  import iterative_multiplier_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic                        clk,
  input  logic                        reset,
  iterative_multiplier_if.slave       bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  mult_state_e        r_state;
  logic [1:0]         r_mode;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;

  logic               w_smulh_in;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_fix_neg;
  logic [2*WIDTH-1:0] w_acc_fix;
  logic [WIDTH-1:0]   w_sel;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mplr_next;
  logic               w_last;

  // Only SMULH works on magnitudes; MUL and UMULH use the raw bit patterns.
  assign w_smulh_in = (bus.mode == MODE_SMULH);
  assign w_neg_a    = w_smulh_in & bus.a[WIDTH-1];
  assign w_neg_b    = w_smulh_in & bus.b[WIDTH-1];

  twos_negate #(.SIZE(WIDTH)) u_abs_a (
    .i_neg (w_neg_a),
    .i_in  (bus.a),
    .o_out (w_abs_a)
  );

  twos_negate #(.SIZE(WIDTH)) u_abs_b (
    .i_neg (w_neg_b),
    .i_in  (bus.b),
    .o_out (w_abs_b)
  );

  // Sign restore: the magnitude product is negated when exactly one signed
  // operand was negative.
  assign w_fix_neg = (r_mode == MODE_SMULH) & (r_sign_a ^ r_sign_b);

  twos_negate #(.SIZE(2*WIDTH)) u_fixup (
    .i_neg (w_fix_neg),
    .i_in  (r_acc),
    .o_out (w_acc_fix)
  );

  assign w_sel = is_high_half(r_mode) ? w_acc_fix[2*WIDTH-1:WIDTH]
                                      : w_acc_fix[WIDTH-1:0];

  // One shift-add step; the sum never carries past bit 2*WIDTH-1.
  assign w_acc_next  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplr_next = r_mplr >> 1;

`ifdef MULT_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain after this step.
  assign w_last = (r_cnt == LAST_CNT) || (w_mplr_next == {WIDTH{1'b0}});
`else
  assign w_last = (r_cnt == LAST_CNT);
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_MUL;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mplr   <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mode   <= bus.mode;
            r_sign_a <= bus.a[WIDTH-1];
            r_sign_b <= bus.b[WIDTH-1];
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplr   <= w_abs_b;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= ST_BUSY;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= w_mplr_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= ST_FIXUP;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_FIXUP: begin
          r_result <= w_sel;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          // Any start seen here is dropped; the next IDLE cycle can accept.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_iterative_multiplier.sv
// -----------------------------------------------------------------------------
// tb_iterative_multiplier
// Directed, table-driven bench for iterative_multiplier: product values for
// all modes, latency, busy span, done pulse width, ignored starts,
// back-to-back acceptance and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_iterative_multiplier;
  import iterative_multiplier_pkg::*;

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  iterative_multiplier_if #(.WIDTH(64)) bus ();

  iterative_multiplier #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Expected cycles from the accepting edge to the done sample.
  function automatic int exp_lat(input logic [1:0] mode, input logic [63:0] b);
    logic [63:0] mag;
    int          idx;
    mag = (mode == 2'b01 && b[63]) ? (~b + 64'd1) : b;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) idx = i;
    end
    return EARLY ? (idx + 3) : 66;
  endfunction

  // Drive a request (unless already driven), drop start after the accepting
  // edge and scramble the inputs so later changes are shown to be harmless.
  task automatic start_op(input logic [1:0] mode, input logic [63:0] a,
                          input logic [63:0] b, input bit preloaded);
    if (!preloaded) begin
      @(negedge clk);
      bus.mode  = mode;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = b ^ 64'h5A5A_A5A5_0F0F_F0F0;
    bus.mode  = ~mode;
  endtask

  task automatic run_check(input string name, input logic [1:0] mode,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int pulse_at,
                           input bit hold_next, input bit preloaded);
    int lat;
    int busy_bad;
    bit timed_out;
    lat       = 0;
    busy_bad  = 0;
    timed_out = 1'b1;
    start_op(mode, a, b, preloaded);
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.done === 1'b1) begin
        lat       = n;
        timed_out = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (pulse_at > 0) begin
        if (n == pulse_at) begin
          bus.start = 1'b1;
          bus.a     = 64'd9;
          bus.b     = 64'd9;
        end else if (n == pulse_at + 1) begin
          bus.start = 1'b0;
        end
      end
    end
    if (timed_out) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 200 cycles", name);
      bus.start = 1'b0;
    end else begin
      check({name, "_result"}, bus.result, exp);
      check({name, "_latency"}, 64'(lat), 64'(exp_lat(mode, b)));
      check({name, "_busy_span"}, 64'(busy_bad), 64'd0);
      check({name, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
      if (hold_next) begin
        bus.mode  = MODE_MUL;
        bus.a     = 64'd9;
        bus.b     = 64'd9;
        bus.start = 1'b1;
      end
      @(negedge clk);
      check({name, "_done_width"}, {63'd0, bus.done}, 64'd0);
      check({name, "_idle_busy"}, {63'd0, bus.busy}, 64'd0);
      check({name, "_result_held"}, bus.result, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"mul_3x5",       MODE_MUL,   64'd3,                  64'd5,                  64'd15};
    vecs[1]  = '{"smulh_m1x1",    MODE_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{"umulh_ones_x1", MODE_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'h0};
    vecs[3]  = '{"mul_ones_x1",   MODE_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{"umulh_ones_sq", MODE_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5]  = '{"smulh_min_sq",  MODE_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[6]  = '{"mul_m2x3",      MODE_MUL,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFA};
    vecs[7]  = '{"smulh_m2x3",    MODE_SMULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{"umulh_2p63x4",  MODE_UMULH, 64'h8000_0000_0000_0000, 64'd4,                  64'd2};
    vecs[9]  = '{"smulh_max_sq",  MODE_SMULH, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF};
    vecs[10] = '{"mode11_7x6",    2'b11,      64'd7,                  64'd6,                  64'd42};
    vecs[11] = '{"mul_5x1",       MODE_MUL,   64'd5,                  64'd1,                  64'd5};
    vecs[12] = '{"smulh_3xm5",    MODE_SMULH, 64'd3,                  64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[13] = '{"mul_x0",        MODE_MUL,   64'h1234,               64'd0,                  64'd0};

    bus.start = 1'b0;
    bus.mode  = MODE_MUL;
    bus.a     = 64'd0;
    bus.b     = 64'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy",   {63'd0, bus.busy}, 64'd0);
    check("reset_done",   {63'd0, bus.done}, 64'd0);
    check("reset_result", bus.result, 64'd0);
    rst_n = 1'b1;

    // Table of single operations.
    for (int i = 0; i < 14; i++) begin
      run_check(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0, 1'b0);
    end

    // Starts mid-BUSY and in the DONE cycle are ignored; start held into the
    // following IDLE cycle is accepted.
    run_check("mul_7x6_ignore", MODE_MUL, 64'd7, 64'd6, 64'd42, 3, 1'b1, 1'b0);
    run_check("mul_9x9_b2b",    MODE_MUL, 64'd9, 64'd9, 64'd81, 0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of BUSY.
    start_op(MODE_MUL, 64'd7, 64'd6, 1'b0);
    repeat (19) @(negedge clk);
    check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy",   {63'd0, bus.busy}, 64'd0);
    check("async_reset_done",   {63'd0, bus.done}, 64'd0);
    check("async_reset_result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("mul_2x2_after_reset", MODE_MUL, 64'd2, 64'd2, 64'd4, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
